// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : 32-bit iterative multiply/divide unit with HI/LO result registers
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mthi,
    input  logic        mtlo,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        done,
    output logic        dbz
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opb_q, opb_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quot_q, quot_d;
    logic        neg_q, neg_d;
    logic        rneg_q, rneg_d;
    logic        dbzp_q, dbzp_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    logic        w_signed;
    logic        w_is_div;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_sum;
    logic [33:0] w_shift;
    logic [33:0] w_diff;
    logic [63:0] w_prod;

    assign w_signed = ~op[0];
    assign w_is_div = op[1];
    assign w_a_mag  = (w_signed && A[31]) ? (~A + 32'd1) : A;
    assign w_b_mag  = (w_signed && B[31]) ? (~B + 32'd1) : B;

    // Shift-add: add multiplicand into the upper half, then shift right with carry.
    assign w_sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    // Restoring divide: shift next dividend bit in, keep difference if non-negative.
    assign w_shift  = {rem_q, quot_q[31]};
    assign w_diff   = w_shift - {2'b00, opb_q};
    assign w_prod   = neg_q ? (~acc_q + 64'd1) : acc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dbzp_d  = dbzp_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mthi || mtlo) begin
                    if (mthi) hi_d = A;
                    if (mtlo) lo_d = A;
                end else if (start) begin
                    op_d   = op;
                    neg_d  = w_signed & (A[31] ^ B[31]);
                    rneg_d = w_signed & w_is_div & A[31];
                    acc_d  = {32'd0, w_a_mag};
                    quot_d = w_a_mag;
                    opb_d  = w_b_mag;
                    rem_d  = 33'd0;
                    cnt_d  = 5'd0;
                    dbzp_d = w_is_div && (B == 32'd0);
                    state_d = (w_is_div && (B == 32'd0)) ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (op_q[1]) begin
                    if (!w_diff[33]) rem_d = w_diff[32:0];
                    else             rem_d = w_shift[32:0];
                    quot_d = {quot_q[30:0], ~w_diff[33]};
                end else begin
                    acc_d = {w_sum, acc_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                dbz_d   = dbzp_q;
                if (!dbzp_q) begin
                    if (op_q[1]) begin
                        lo_d = neg_q  ? (~quot_q + 32'd1) : quot_q;
                        hi_d = rneg_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
                    end else begin
                        hi_d = w_prod[63:32];
                        lo_d = w_prod[31:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 2'd0;
            acc_q   <= 64'd0;
            opb_q   <= 32'd0;
            rem_q   <= 33'd0;
            quot_q  <= 32'd0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dbzp_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dbzp_q  <= dbzp_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign dbz  = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : directed self-checking bench for muldiv_unit
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mthi;
    logic        mtlo;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;
    logic        dbz;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    muldiv_unit u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .A       (A),
        .B       (B),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .HI      (HI),
        .LO      (LO),
        .busy    (busy),
        .done    (done),
        .dbz     (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Launch one op; returns the number of falling edges from launch until done seen.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op_check(input string tag, input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int lat;
        run_op(o, a, b, lat);
        check({tag, "_lat"}, 64'(lat), 64'd34);
        check({tag, "_hilo"}, {HI, LO}, {ehi, elo});
        check({tag, "_dbz"}, {63'd0, dbz}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int lat;
        int busy_low;
        int done_seen;
        reset_n = 1'b0; start = 1'b0; op = 2'b00; A = 32'd0; B = 32'd0;
        mthi = 1'b0; mtlo = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", {HI, LO}, 64'd0);
        check("reset_flags", {61'd0, busy, done, dbz}, 64'd0);
        reset_n = 1'b1;

        // Moves into HI and LO
        @(negedge clk); A = 32'h11; mthi = 1'b1;
        @(negedge clk); mthi = 1'b0; A = 32'h22; mtlo = 1'b1;
        @(negedge clk); mtlo = 1'b0;
        check("mthi_mtlo", {HI, LO}, {32'h11, 32'h22});

        // Move wins over a simultaneous start
        A = 32'h22; mtlo = 1'b1; start = 1'b1; op = OP_MULTU; B = 32'd5;
        @(negedge clk); mtlo = 1'b0; start = 1'b0;
        check("move_beats_start", {63'd0, busy}, 64'd0);

        // Divide by zero: HI/LO untouched, done+dbz after E1
        run_op(OP_DIVU, 32'd9, 32'd0, lat);
        check("dbz_lat", 64'(lat), 64'd2);
        check("dbz_flag", {62'd0, done, dbz}, 64'd3);
        check("dbz_hilo", {HI, LO}, {32'h11, 32'h22});
        @(negedge clk);
        check("dbz_clear", {62'd0, done, dbz}, 64'd0);

        op_check("mult_neg",   OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
        op_check("multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        op_check("mult_min",   OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        op_check("div_neg",    OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        op_check("divu_7_2",   OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003);
        op_check("div_negdiv", OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        op_check("div_wrap",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        @(negedge clk);
        check("done_one_cycle", {62'd0, done, dbz}, 64'd0);

        // MULT 5*7 with a stray start at E10 and mthi at E12, both ignored
        @(negedge clk);
        op = OP_MULT; A = 32'd5; B = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_low = 0;
        while (!done && lat < 60) begin
            if (lat <= 33 && !busy) busy_low++;
            @(negedge clk);
            lat++;
            if (lat == 10) begin start = 1'b1; op = OP_DIVU; A = 32'd100; B = 32'd0; end
            if (lat == 11) start = 1'b0;
            if (lat == 12) begin mthi = 1'b1; A = 32'hDEAD; end
            if (lat == 13) mthi = 1'b0;
        end
        check("ignore_lat", 64'(lat), 64'd34);
        check("ignore_busy", 64'(busy_low), 64'd0);
        check("ignore_hilo", {HI, LO}, {32'd0, 32'd35});
        repeat (2) @(negedge clk);
        check("ignore_no_restart", {62'd0, busy, done}, 64'd0);

        // Reset asserted at E20 of a DIV
        @(negedge clk);
        op = OP_DIV; A = 32'd1000; B = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_hilo", {HI, LO}, 64'd0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || dbz) done_seen++;
        end
        check("rst_no_done", 64'(done_seen), 64'd0);
        reset_n = 1'b1; op = OP_DIVU; A = 32'd100; B = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_first_edge", {63'd0, busy}, 64'd1);
        lat = 1;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("rst_after_lat", 64'(lat), 64'd34);
        check("rst_after_hilo", {HI, LO}, {32'd2, 32'd14});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 32 bits.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request a multiply or divide using op, A, B.
REQ-006 op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-007 A  input  32  multiplicand or dividend; also the data source for mthi/mtlo.
REQ-008 B  input  32  multiplier or divisor.
REQ-009 mthi  input  1  write A into HI.
REQ-010 mtlo  input  1  write A into LO.
REQ-011 HI  output  32  high product word or remainder.
REQ-012 LO  output  32  low product word or quotient.
REQ-013 busy  output  1  operation in progress; high while the state is not IDLE.
REQ-014 done  output  1  one-cycle pulse when HI/LO are final.
REQ-015 dbz  output  1  divide-by-zero flag, valid only while done=1.

Function
REQ-016 The block SHALL implement the states IDLE, RUN and FIX.
REQ-017 In IDLE with start=1 at edge E0, the block SHALL:
- latch op, A and B;
- load operand magnitudes, or raw values for unsigned ops;
- record the result signs;
- set cnt=0 and enter RUN, so busy=1 after E0.
REQ-018 In RUN, each edge SHALL perform one iteration, for 32 iterations (E1..E32):
- multiply: shift-add;
- divide: restoring shift-subtract.
At E32 the state SHALL become FIX.
REQ-019 Product and remainder accumulators SHALL be 64 and 33 bits wide respectively, with no truncation before FIX.
REQ-020 At E33 (in FIX) the block SHALL:
- apply the sign correction;
- write HI and LO;
- enter IDLE;
- drive done=1 for exactly the cycle following E33, with busy=0 in that cycle.
REQ-021 Multiply results SHALL be HI = product[63:32] and LO = product[31:0].
- MULT: signed 64-bit product.
- MULTU: unsigned 64-bit product.
REQ-022 Divide results SHALL be LO = quotient and HI = remainder.
- Signed quotient is negative iff the operand signs differ.
- Signed remainder takes the dividend's sign.
REQ-023 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0 (wrap, no trap).
REQ-024 DIV or DIVU with B=0 SHALL skip RUN, going IDLE->FIX at E0; at E1 HI and LO stay unchanged and done=1, dbz=1 follow.
REQ-025 dbz SHALL be 0 whenever done=0, and for every non-zero-divisor completion.
REQ-026 start SHALL be ignored while state != IDLE; a new start is accepted at the first edge where state=IDLE (E34 at the earliest).
REQ-027 mthi/mtlo SHALL take effect at the sampling edge only in IDLE; they are ignored while busy.
REQ-028 If start and mthi/mtlo are sampled together in IDLE, the move SHALL be performed and start SHALL be ignored.
REQ-029 HI and LO SHALL hold their values at all times other than FIX completion or an accepted move.

Reset
REQ-030 While reset_n=0, regardless of clk, the block SHALL force:
- state=IDLE and cnt=0;
- HI=0 and LO=0;
- busy=0, done=0 and dbz=0.
REQ-031 Reset asserted mid-RUN or in FIX SHALL abort the operation with no HI/LO update and no done pulse.
REQ-032 After reset_n deasserts, start SHALL be accepted at the first rising edge.

Verification
REQ-033 MULT A=0xFFFFFFFE(-2), B=0x00000003 -> done in the cycle after E33, HI=0xFFFFFFFF, LO=0xFFFFFFFA, dbz=0.
REQ-034 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-035 DIV A=0xFFFFFFF9(-7), B=2 -> LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1); DIVU 7/2 -> LO=3, HI=1.
REQ-036 With HI=0x11 and LO=0x22, DIVU B=0 -> done=1 and dbz=1 at the cycle after E1; HI=0x11 and LO=0x22 unchanged.
REQ-037 start pulsed again at E10 of a MULT, plus mthi=1 at E12 -> both ignored; first result delivered intact; busy stays high through E32.
REQ-038 reset_n driven low at E20 of a DIV -> immediate busy=0 and HI=LO=0; no done pulse; new start after release completes normally.
